// File: rtl/alu_mdu_controller.sv
// EX-stage ALU controller with an iterative multiply/divide unit.
// The ALU control code is decoded combinationally from {ALUOp, func}.
// MULT/MULTU/DIV/DIVU iterate one bit per cycle for WIDTH cycles and then
// write HI/LO. MFHI/MFLO read HI/LO. Any MDU-dependent instruction that
// arrives while the unit is iterating stalls the front of the pipe.
module alu_mdu_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       Q,
    output logic             illegal,
    output logic             sel_mdu,
    output logic [WIDTH-1:0] mdu_out,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] p_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   m_q;      // mul: multiplicand magnitude; div: divisor magnitude
    logic               negq_q;   // negate product / quotient at the end
    logic               negr_q;   // negate remainder (dividend was negative)
    logic               dz_q;     // divide by zero
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic is_md, is_mfhi, is_mflo, md_signed, md_div;
    logic accept, step, last;

    // Decode {ALUOp, func} into ALU control and MDU operation class
    always_comb begin
        Q         = 3'b010;
        illegal   = 1'b0;
        is_md     = 1'b0;
        is_mfhi   = 1'b0;
        is_mflo   = 1'b0;
        md_signed = 1'b0;
        md_div    = 1'b0;
        case (ALUOp)
            2'b00: Q = 3'b010;
            2'b01: Q = 3'b011;
            2'b11: Q = 3'b000;
            default: begin
                case (func)
                    6'b100100: Q = 3'b000;
                    6'b100101: Q = 3'b001;
                    6'b100000: Q = 3'b010;
                    6'b100010: Q = 3'b011;
                    6'b101010: Q = 3'b111;
                    6'b011000: begin is_md = 1'b1; md_signed = 1'b1; end
                    6'b011001: begin is_md = 1'b1; end
                    6'b011010: begin is_md = 1'b1; md_signed = 1'b1; md_div = 1'b1; end
                    6'b011011: begin is_md = 1'b1; md_div = 1'b1; end
                    6'b010000: is_mfhi = 1'b1;
                    6'b010010: is_mflo = 1'b1;
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Hazard handling and HI/LO read port
    always_comb begin
        stall   = in_valid & (is_md | is_mfhi | is_mflo) & busy_q;
        sel_mdu = in_valid & (is_mfhi | is_mflo) & ~stall;
        mdu_out = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: leave IDLE on an accepted op, return after the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid & is_md) state_d = md_div ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (cnt_q == CW'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accept, iterate, final iteration
    always_comb begin
        accept = (state_q == S_IDLE) & in_valid & is_md;
        step   = (state_q != S_IDLE);
        last   = step & (cnt_q == CW'(1));
    end

    // One-bit-per-cycle datapath: shift-add multiply, restoring divide
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_p, div_p, prod;
    logic [WIDTH-1:0]   quo, rem, hi_d, lo_d;
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    always_comb begin
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_p    = {mul_sum, p_q[WIDTH-1:1]};
        div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_p    = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        prod     = negq_q ? -mul_p : mul_p;
        quo      = div_p[WIDTH-1:0];
        rem      = div_p[2*WIDTH-1:WIDTH];
        if (state_q == S_DIV) begin
            // With a zero divisor the remainder ends up as |a|; restoring its
            // sign yields a unchanged, while the quotient is forced to all ones.
            lo_d = dz_q ? '1 : (negq_q ? -quo : quo);
            hi_d = negr_q ? -rem : rem;
        end else begin
            lo_d = prod[WIDTH-1:0];
            hi_d = prod[2*WIDTH-1:WIDTH];
        end
        sa    = md_signed & a[WIDTH-1];
        sb    = md_signed & b[WIDTH-1];
        abs_a = sa ? -a : a;
        abs_b = sb ? -b : b;
    end

    // Operand capture, iteration and HI/LO writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            p_q    <= '0;
            m_q    <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= last;
            if (accept) begin
                cnt_q  <= CW'(WIDTH);
                p_q    <= {{WIDTH{1'b0}}, md_div ? abs_a : abs_b};
                m_q    <= md_div ? abs_b : abs_a;
                negq_q <= sa ^ sb;
                negr_q <= sa;
                dz_q   <= (b == '0);
            end else if (step) begin
                cnt_q <= cnt_q - CW'(1);
                p_q   <= (state_q == S_DIV) ? div_p : mul_p;
                if (last) begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Directed bench for alu_mdu_controller: decode sweep, MDU results via a
// scoreboard queue, stall/forwarding, mid-iteration reset, WIDTH=8 corners.
module tb_alu_mdu_controller;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  ALUOp;
    logic [5:0]  func;
    logic [31:0] a, b;
    logic [2:0]  Q;
    logic        illegal, sel_mdu, stall, busy, done;
    logic [31:0] mdu_out, hi, lo;

    logic        in_valid8;
    logic [1:0]  ALUOp8;
    logic [5:0]  func8;
    logic [7:0]  a8, b8;
    logic [2:0]  Q8;
    logic        illegal8, sel_mdu8, stall8, busy8, done8;
    logic [7:0]  mdu_out8, hi8, lo8;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    alu_mdu_controller #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ALUOp(ALUOp), .func(func),
        .a(a), .b(b), .Q(Q), .illegal(illegal), .sel_mdu(sel_mdu),
        .mdu_out(mdu_out), .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    alu_mdu_controller #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .ALUOp(ALUOp8), .func(func8),
        .a(a8), .b(b8), .Q(Q8), .illegal(illegal8), .sel_mdu(sel_mdu8),
        .mdu_out(mdu_out8), .stall(stall8), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: {illegal, Q}
    function automatic logic [3:0] dec_model(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00: return 4'b0_010;
            2'b01: return 4'b0_011;
            2'b11: return 4'b0_000;
            default: case (f)
                6'd36: return 4'b0_000;
                6'd37: return 4'b0_001;
                6'd32: return 4'b0_010;
                6'd34: return 4'b0_011;
                6'd42: return 4'b0_111;
                6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd18: return 4'b0_010;
                default: return 4'b1_010;
            endcase
        endcase
    endfunction

    // Issue an MDU op at the current negedge, expect it back after 32 busy cycles
    task automatic run_md(input string tag, input logic [5:0] f,
                          input logic [31:0] aa, input logic [31:0] bb,
                          input logic [63:0] exp);
        int n;
        logic [63:0] e;
        sb_q.push_back(exp);
        ALUOp = 2'b10; func = f; a = aa; b = bb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk({tag, "_lat"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_sb"}, 64'(sb_q.size() != 0), 64'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'd0;
        chk({tag, "_hilo"}, {hi, lo}, e);
        @(negedge clk);
        chk({tag, "_done1"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n, bad;
        logic [3:0]  d;
        logic [63:0] e;
        longint      pa, pb;
        int          da, db;

        rst = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; func = '0; a = '0; b = '0;
        in_valid8 = 1'b0; ALUOp8 = 2'b10; func8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_hilo8", 64'({hi8, lo8}), 64'd0);
        rst = 1'b0;

        // 1: decode sweep (in_valid low so nothing is accepted)
        bad = 0;
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                ALUOp = 2'(op); func = 6'(f);
                #1;
                d = dec_model(2'(op), 6'(f));
                checks++;
                assert ({illegal, Q} === d) else begin
                    errors++; bad++;
                    if (bad < 5) $error("FAIL decode op=%0d f=%0d observed=%b expected=%b",
                                        op, f, {illegal, Q}, d);
                end
            end
        end
        ALUOp = 2'b10; func = 6'b111111; #1;
        chk("dec_ff_illegal", 64'(illegal), 64'd1);
        chk("dec_ff_Q", 64'(Q), 64'd2);
        @(negedge clk);

        // 2, 3: multiply / divide results and corners
        run_md("mult", 6'b011000, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
        run_md("multu", 6'b011001, 32'hFFFFFFFD, 32'd7, 64'h00000006_FFFFFFEB);
        run_md("div", 6'b011010, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_md("divu_z", 6'b011011, 32'd7, 32'd0, 64'h00000007_FFFFFFFF);
        run_md("div_z", 6'b011010, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF);
        run_md("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_md("divu_big", 6'b011011, 32'hFFFFFFFF, 32'd16, 64'h0000000F_0FFFFFFF);
        for (int k = 0; k < 2; k++) begin
            a = $urandom; b = $urandom;
            pa = longint'($signed(a)); pb = longint'($signed(b));
            e = 64'(pa * pb);
            run_md("mult_rnd", 6'b011000, a, b, e);
            da = $signed(a); db = int'($urandom_range(1, 1000));
            if (k == 1) db = -db;
            e = {32'(da % db), 32'(da / db)};
            run_md("div_rnd", 6'b011010, a, 32'(db), e);
        end

        // 4: add passes while busy, mflo stalls until done then forwards
        sb_q.push_back(64'hFFFFFFFF_FFFFFFEC);
        ALUOp = 2'b10; func = 6'b011000; a = 32'd5; b = 32'hFFFFFFFC; in_valid = 1'b1;
        @(negedge clk);
        func = 6'b100000; #1;
        chk("add_busy", 64'(busy), 64'd1);
        chk("add_stall", 64'(stall), 64'd0);
        chk("add_Q", 64'(Q), 64'd2);
        chk("add_sel", 64'(sel_mdu), 64'd0);
        @(negedge clk);
        func = 6'b010010;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 100) begin
            #1;
            if (stall !== 1'b1 || sel_mdu !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        #1;
        chk("mflo_stall_cycles", 64'(n), 64'd31);
        chk("mflo_stall_level", 64'(bad), 64'd0);
        chk("mflo_done", 64'(done), 64'd1);
        chk("mflo_nostall", 64'(stall), 64'd0);
        chk("mflo_sel", 64'(sel_mdu), 64'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'd0;
        chk("mflo_out", 64'(mdu_out), 64'(e[31:0]));
        func = 6'b010000; #1;
        chk("mfhi_out", 64'(mdu_out), 64'(e[63:32]));
        in_valid = 1'b0;
        @(negedge clk);

        // 5: reset in the middle of a divide discards it
        func = 6'b011010; a = 32'd100; b = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 10) begin n++; @(negedge clk); end
        chk("rst_mid_cnt", 64'(n), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        // reset beats a simultaneous request
        func = 6'b011000; in_valid = 1'b1;
        @(negedge clk);
        chk("rst_wins", 64'(busy), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        run_md("mult_post_rst", 6'b011001, 32'd12, 32'd11, 64'd132);

        // 6: WIDTH=8 corners
        in_valid8 = 1'b1; func8 = 6'b011000; a8 = 8'h80; b8 = 8'hFF; #1;
        chk("w8_Q", 64'(Q8), 64'd2);
        chk("w8_flags", 64'({illegal8, sel_mdu8, stall8}), 64'd0);
        chk("w8_mdu_out", 64'(mdu_out8), 64'd0);
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (busy8 === 1'b1 && n < 50) begin n++; @(negedge clk); end
        chk("w8_mul_lat", 64'(n), 64'd8);
        chk("w8_mul_done", 64'(done8), 64'd1);
        chk("w8_mul_hilo", 64'({hi8, lo8}), 64'h0080);
        in_valid8 = 1'b1; func8 = 6'b011010; a8 = 8'h80; b8 = 8'hFF;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (busy8 === 1'b1 && n < 50) begin n++; @(negedge clk); end
        chk("w8_div_lat", 64'(n), 64'd8);
        chk("w8_div_done", 64'(done8), 64'd1);
        chk("w8_div_hilo", 64'({hi8, lo8}), 64'h0080);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
